// File: rtl/aud_i2s_player.sv
// -----------------------------------------------------------------------------
// aud_i2s_player
//
// Serialises a signed DATA_W-bit sample from the audio DSP stage onto the
// WM8731 DACDAT line in I2S format. The codec bit clock (BCLK) is the only clock.
// The codec's DAC LR clock frames the slots: low = left, high = right.
// Each slot's MSB goes out one BCLK after the LRCK edge (the I2S delay slot).
//
// A new sample and the mute request are captured only at left-slot starts.
// Both halves of a frame therefore always carry the same data and mute setting.
//
// Ports
//   i_clk         codec bit clock; all logic on its rising edge
//   i_rst         asynchronous, active-high reset
//   i_daclrck     codec DAC LR clock (0 = left slot, 1 = right slot)
//   i_en          sample valid from the DSP stage
//   i_dac_data    signed sample from the DSP stage
//   i_mute        force zero output, takes effect at the next left slot
//   o_aud_dacdat  registered serial data to the codec
//   o_active      high while a slot's DATA_W data bits are being driven
//   o_underrun    1-cycle pulse: a left slot started without a valid sample
//   o_frame_err   1-cycle pulse: an LRCK edge cut a slot short
//   o_frame_cnt   count of left-slot starts, wraps at 16 bits
//
// Parameters
//   DATA_W        sample width and number of bits sent per slot
//   CHANNEL_MODE  0 = sample on both slots, 1 = left only (right sends zeros)
// -----------------------------------------------------------------------------
module aud_i2s_player #(
  parameter int DATA_W       = 16,
  parameter int CHANNEL_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dac_data,
  input  logic              i_mute,
  output logic              o_aud_dacdat,
  output logic              o_active,
  output logic              o_underrun,
  output logic              o_frame_err,
  output logic [15:0]       o_frame_cnt
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic                lrck_q;
  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   shift_q;
  logic                mute_q;
  logic [CNT_W-1:0]    bit_cnt_q;

  logic                lrck_edge;
  logic                lrck_fall;
  logic                lrck_rise;
  logic                load_left;
  logic                load_right;
  logic                shift_en;
  logic                abort;
  logic [DATA_W-1:0]   sample_d;
  logic [DATA_W-1:0]   load_word;

  // The edge is seen one BCLK late because it is compared with the registered
  // copy. That delay is the I2S one-bit offset, so nothing else has to create it.
  assign lrck_edge = (i_daclrck != lrck_q);
  assign lrck_fall = lrck_edge & ~i_daclrck;
  assign lrck_rise = lrck_edge &  i_daclrck;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_left  = 1'b0;
    load_right = 1'b0;
    shift_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Only a left slot starts playback, so frames always begin on the left.
        if (lrck_fall) begin
          load_left = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (lrck_edge) begin
          load_left  = lrck_fall;
          load_right = lrck_rise;
        end else if (bit_cnt_q == CNT_W'(1)) begin
          state_d = S_HOLD;
        end else begin
          shift_en = 1'b1;
        end
      end

      S_HOLD: begin
        if (lrck_edge) begin
          load_left  = lrck_fall;
          load_right = lrck_rise;
          state_d    = S_SHIFT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // An edge is early only while bits beyond the current one are still owed.
  assign abort = (state_q == S_SHIFT) && lrck_edge && (bit_cnt_q > CNT_W'(1));

  // When i_en is low the previous sample is repeated.
  assign sample_d = i_en ? i_dac_data : sample_q;

  always_comb begin
    load_word = '0;
    if (load_left) begin
      // Mute uses the value being captured now, so it covers this whole frame.
      load_word = i_mute ? '0 : sample_d;
    end else if (load_right) begin
      load_word = (mute_q || (CHANNEL_MODE != 0)) ? '0 : sample_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the clock edge, whatever the statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      lrck_q       <= 1'b0;
      sample_q     <= '0;
      shift_q      <= '0;
      mute_q       <= 1'b0;
      bit_cnt_q    <= '0;
      o_aud_dacdat <= 1'b0;
      o_active     <= 1'b0;
      o_underrun   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      lrck_q      <= i_daclrck;
      state_q     <= state_d;
      o_underrun  <= load_left & ~i_en;
      o_frame_err <= abort;

      if (load_left) begin
        sample_q    <= sample_d;
        mute_q      <= i_mute;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end

      // The MSB goes straight to the output register. The shift register keeps
      // only the bits that are still owed.
      if (load_left || load_right) begin
        o_aud_dacdat <= load_word[DATA_W-1];
        shift_q      <= load_word << 1;
        bit_cnt_q    <= CNT_W'(DATA_W);
        o_active     <= 1'b1;
      end else if (shift_en) begin
        o_aud_dacdat <= shift_q[DATA_W-1];
        shift_q      <= shift_q << 1;
        bit_cnt_q    <= bit_cnt_q - CNT_W'(1);
      end else begin
        o_aud_dacdat <= 1'b0;
        o_active     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aud_i2s_player.sv
// -----------------------------------------------------------------------------
// tb_aud_i2s_player
//
// Two players share one set of inputs, one with CHANNEL_MODE 0 and one with
// CHANNEL_MODE 1. Stimulus is issued one LRCK slot at a time. For each slot
// the slot-level model works out the word that slot should carry. It then
// queues the expected per-BCLK outputs, each tagged with its cycle number.
// A separate monitor pops and compares every tagged cycle on the falling clock.
// -----------------------------------------------------------------------------
module tb_aud_i2s_player;

  localparam int DATA_W = 16;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        lrck = 1'b1;
  logic        en   = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] data = 16'h0000;

  logic        dac0, act0, und0, err0;
  logic        dac1, act1, und1, err1;
  logic [15:0] cnt0, cnt1;

  always #5 clk = ~clk;

  aud_i2s_player #(.DATA_W(DATA_W), .CHANNEL_MODE(0)) dut_stereo (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_daclrck   (lrck),
    .i_en        (en),
    .i_dac_data  (data),
    .i_mute      (mute),
    .o_aud_dacdat(dac0),
    .o_active    (act0),
    .o_underrun  (und0),
    .o_frame_err (err0),
    .o_frame_cnt (cnt0)
  );

  aud_i2s_player #(.DATA_W(DATA_W), .CHANNEL_MODE(1)) dut_left_only (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_daclrck   (lrck),
    .i_en        (en),
    .i_dac_data  (data),
    .i_mute      (mute),
    .o_aud_dacdat(dac1),
    .o_active    (act1),
    .o_underrun  (und1),
    .o_frame_err (err1),
    .o_frame_cnt (cnt1)
  );

  typedef struct packed {
    logic        dac0;
    logic        dac1;
    logic        active;
    logic        underrun;
    logic        frame_err;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } sb_t;

  sb_t sb_q[$];
  int  cyc      = 0;
  int  n_checks = 0;
  int  n_pass   = 0;

  // Slot-level reference state
  logic [15:0] m_sample;
  logic [15:0] m_cnt;
  logic        m_mute;
  logic        m_started;
  logic        m_prev_short;
  logic        m_lrck;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Monitor: one expected entry per tagged BCLK, compared in mid-cycle.
  always @(negedge clk) begin
    sb_t s;
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
      s = sb_q.pop_front();
      check("serial_out",
            64'({dac0, dac1, act0, act1, und0, und1, err0, err1, cnt0, cnt1}),
            64'({s.e.dac0, s.e.dac1, s.e.active, s.e.active, s.e.underrun,
                 s.e.underrun, s.e.frame_err, s.e.frame_err, s.e.cnt, s.e.cnt}));
    end
  end

  // Drive one LRCK slot of len BCLKs. The edge cycle carries the slot's
  // en/data/mute values, and every other cycle carries random values.
  task automatic slot(input logic lr, input int len, input logic s_en,
                      input logic [15:0] s_data, input logic s_mute);
    logic        edge_seen, left, loaded, und, err;
    logic [15:0] w0, w1;
    exp_t        e;
    sb_t         s;
    edge_seen = (lr != m_lrck);
    left      = edge_seen && !lr;
    loaded    = edge_seen && (m_started || left);
    err       = loaded && m_prev_short;
    und       = left && !s_en;
    w0 = 16'h0000;
    w1 = 16'h0000;
    if (left) begin
      m_started = 1'b1;
      if (s_en) m_sample = s_data;
      m_mute = s_mute;
      m_cnt  = m_cnt + 16'd1;
      w0 = s_mute ? 16'h0000 : m_sample;
      w1 = w0;
    end else if (loaded) begin
      w0 = m_mute ? 16'h0000 : m_sample;
      w1 = 16'h0000;
    end
    m_prev_short = loaded && (len < DATA_W);
    m_lrck       = lr;
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      lrck = lr;
      if (c == 0) begin
        en = s_en; data = s_data; mute = s_mute;
      end else begin
        en = 1'($urandom); data = 16'($urandom); mute = 1'($urandom);
      end
      e.dac0      = (loaded && c < DATA_W) ? w0[DATA_W-1-c] : 1'b0;
      e.dac1      = (loaded && c < DATA_W) ? w1[DATA_W-1-c] : 1'b0;
      e.active    = loaded && (c < DATA_W);
      e.underrun  = (c == 0) && und;
      e.frame_err = (c == 0) && err;
      e.cnt       = m_cnt;
      s.cyc = cyc + 1;
      s.e   = e;
      sb_q.push_back(s);
    end
  endtask

  task automatic right(input int len);
    slot(1'b1, len, 1'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Assert reset mid-cycle, once the last queued cycle has been checked.
  // Check that the outputs clear at once, then release with LRCK high.
  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_dacdat", 64'({dac0, dac1}), 64'd0);
    check("rst_active", 64'({act0, act1}), 64'd0);
    check("rst_frame_cnt", 64'({cnt0, cnt1}), 64'd0);
    lrck = 1'b1; en = 1'b0; mute = 1'b0; data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", 64'({dac0, act0, und0, err0, dac1, act1, und1, err1, cnt0, cnt1}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_sample = 16'h0000; m_cnt = 16'h0000; m_mute = 1'b0;
    m_started = 1'b0; m_prev_short = 1'b0; m_lrck = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic lr;
    do_reset();
    right(6);                                   // rising edge after reset is ignored
    slot(1'b0, 20, 1'b1, 16'hA5C3, 1'b0);       // basic left slot
    right(20);                                  // repeat or zeros by channel mode
    slot(1'b0, 20, 1'b1, 16'h8001, 1'b0);
    right(20);
    slot(1'b0, 20, 1'b0, 16'h5555, 1'b0);       // underrun repeats 8001
    right(20);
    slot(1'b0, 20, 1'b1, 16'h7FFF, 1'b1);       // muted frame
    slot(1'b1, 20, 1'b1, 16'h7FFF, 1'b0);       // unmute mid-frame has no effect
    slot(1'b0, 20, 1'b1, 16'h7FFF, 1'b0);
    right(20);
    repeat (3) begin                            // short slots: frame errors
      slot(1'b0, 10, 1'b1, 16'($urandom), 1'b0);
      right(10);
    end
    slot(1'b0, 16, 1'b1, 16'hC3A5, 1'b0);       // exact-length slots
    right(16);
    slot(1'b0, 17, 1'b1, 16'h0F0F, 1'b0);
    right(15);
    slot(1'b0, 7, 1'b1, 16'hFFFF, 1'b0);        // reset during bit 7
    do_reset();
    right(8);
    slot(1'b0, 20, 1'b0, 16'h1234, 1'b0);
    right(20);
    lr = 1'b0;
    repeat (240) begin
      slot(lr, $urandom_range(6, 24), ($urandom_range(0, 3) != 0),
           16'($urandom), ($urandom_range(0, 3) == 0));
      lr = ~lr;
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
